// File: rtl/magnetron_power_ctrl_pkg.sv
// Shared types and defaults for the magnetron power controller.
package magnetron_pkg;

  localparam int unsigned LEVELS_DEFAULT = 10;
  localparam int unsigned LW_DEFAULT     = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COOK  = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/magnetron_power_ctrl_if.sv
// Keypad/door/timer inputs and magnetron/status outputs of the controller.
interface magnetron_power_ctrl_if
  import magnetron_pkg::*;
#(
  parameter int unsigned LW = LW_DEFAULT
);
  logic          startn;
  logic          stopn;
  logic          clearn;
  logic          door_closed;
  logic          timer_done;
  logic          tick;
  logic [LW-1:0] power_level;
  logic          mag_on;
  logic          cooking;
  logic          done;
  logic [1:0]    state;

  modport master (
    output startn, stopn, clearn, door_closed, timer_done, tick, power_level,
    input  mag_on, cooking, done, state
  );

  modport slave (
    input  startn, stopn, clearn, door_closed, timer_done, tick, power_level,
    output mag_on, cooking, done, state
  );
endinterface

// File: rtl/magnetron_power_ctrl_duty.sv
// Duty window counter over LEVELS ticks and the on/off compare against the level.
module power_duty_gen
  import magnetron_pkg::*;
#(
  parameter int unsigned LEVELS = LEVELS_DEFAULT,
  parameter int unsigned LW     = LW_DEFAULT
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          run,
  input  logic          restart,
  input  logic          tick,
  input  logic [LW-1:0] lvl,
  output logic [LW-1:0] win,
  output logic          duty_on
);

  logic [LW-1:0] win_d;
  logic [LW-1:0] win_q;

  always_comb begin
    win_d = win_q;
    if (restart) begin
      win_d = '0;
    end else if (run && tick) begin
      win_d = (win_q == LW'(LEVELS - 1)) ? '0 : win_q + LW'(1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) win_q <= '0;
    else         win_q <= win_d;
  end

  // Compare against the next window slot so mag_on lines up with the new count.
  assign duty_on = (win_d < lvl);
  assign win     = win_q;

endmodule

// File: rtl/magnetron_power_ctrl.sv
// Cook-cycle FSM with start edge detect, level latch and door-safe magnetron enable.
module magnetron_power_ctrl
  import magnetron_pkg::*;
#(
  parameter int unsigned LEVELS = LEVELS_DEFAULT,
  parameter int unsigned LW     = LW_DEFAULT
) (
  input logic                   clk,
  input logic                   resetn,
  magnetron_power_ctrl_if.slave bus
);

  state_t        state_d, state_q;
  logic [LW-1:0] lvl_d, lvl_q;
  logic [LW-1:0] lvl_sat;
  logic [LW-1:0] win_w;
  logic          start_prev_q;
  logic          start_ev;
  logic          mag_on_d, mag_on_q;
  logic          run, restart, duty_on;

  assign start_ev = start_prev_q & ~bus.startn;
  assign lvl_sat  = (bus.power_level > LW'(LEVELS)) ? LW'(LEVELS) : bus.power_level;

  // Next state in priority order: clear, stop, door, timer, start.
  always_comb begin
    state_d = state_q;
    lvl_d   = lvl_q;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.clearn && bus.stopn && bus.door_closed && !bus.timer_done && start_ev) begin
          state_d = ST_COOK;
          lvl_d   = lvl_sat;
        end
      end
      ST_COOK: begin
        if (!bus.clearn)                          state_d = ST_IDLE;
        else if (!bus.stopn || !bus.door_closed)  state_d = ST_PAUSE;
        else if (bus.timer_done)                  state_d = ST_DONE;
      end
      ST_PAUSE: begin
        if (!bus.clearn)                          state_d = ST_IDLE;
        else if (!bus.stopn || !bus.door_closed)  state_d = ST_PAUSE;
        else if (bus.timer_done)                  state_d = ST_DONE;
        else if (start_ev)                        state_d = ST_COOK;
      end
      ST_DONE: begin
        if (!bus.clearn) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign run     = (state_q == ST_COOK) && (state_d == ST_COOK);
  assign restart = (state_d == ST_IDLE) || ((state_q == ST_IDLE) && (state_d == ST_COOK));

  power_duty_gen #(
    .LEVELS (LEVELS),
    .LW     (LW)
  ) u_duty (
    .clk     (clk),
    .resetn  (resetn),
    .run     (run),
    .restart (restart),
    .tick    (bus.tick),
    .lvl     (lvl_d),
    .win     (win_w),
    .duty_on (duty_on)
  );

  // An open door kills the magnetron regardless of FSM state.
  assign mag_on_d = (state_d == ST_COOK) && duty_on && bus.door_closed;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= ST_IDLE;
      lvl_q        <= '0;
      start_prev_q <= 1'b1;
      mag_on_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      lvl_q        <= lvl_d;
      start_prev_q <= bus.startn;
      mag_on_q     <= mag_on_d;
    end
  end

  assign bus.mag_on  = mag_on_q;
  assign bus.state   = state_q;
  assign bus.cooking = (state_q == ST_COOK);
  assign bus.done    = (state_q == ST_DONE);

endmodule

// File: tb/tb_magnetron_power_ctrl.sv
// Directed and random checks of magnetron_power_ctrl against a rule-level model.
module tb_magnetron_power_ctrl;

  localparam int LEVELS = 10;
  localparam int LW     = 4;

  logic clk;
  logic resetn;
  int   n_cmp;
  int   n_err;

  // Reference model: state as 0..3, window slot, latched level, last startn.
  int   m_st;
  int   m_win;
  int   m_lvl;
  int   m_prev;
  int   m_mag;

  magnetron_power_ctrl_if #(.LW(LW)) bus ();

  magnetron_power_ctrl #(.LEVELS(LEVELS), .LW(LW)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_st = 0; m_win = 0; m_lvl = 0; m_prev = 1; m_mag = 0;
  endtask

  // Apply the controller rules to the inputs sampled at this edge.
  task automatic model_step(input int sn, input int stn, input int cn, input int dc,
                            input int td, input int tk, input int pl);
    int nxt;
    int sev;
    sev = (m_prev == 1 && sn == 0) ? 1 : 0;
    m_prev = sn;
    nxt = m_st;
    if (cn == 0) begin
      if (m_st != 0) nxt = 0;
    end else if (m_st == 0) begin
      if (stn == 1 && dc == 1 && td == 0 && sev == 1) nxt = 1;
    end else if (m_st == 1) begin
      if (stn == 0 || dc == 0) nxt = 2;
      else if (td == 1)        nxt = 3;
    end else if (m_st == 2) begin
      if (stn == 1 && dc == 1) begin
        if (td == 1)       nxt = 3;
        else if (sev == 1) nxt = 1;
      end
    end
    if (nxt == 0) begin
      m_win = 0;
    end else if (m_st == 0 && nxt == 1) begin
      m_win = 0;
      m_lvl = (pl > LEVELS) ? LEVELS : pl;
    end else if (m_st == 1 && nxt == 1 && tk == 1) begin
      m_win = (m_win + 1) % LEVELS;
    end
    m_st  = nxt;
    m_mag = (m_st == 1 && m_win < m_lvl && dc == 1) ? 1 : 0;
  endtask

  task automatic cyc(input int sn, input int stn, input int cn, input int dc,
                     input int td, input int tk, input int pl);
    bus.startn      = sn[0];
    bus.stopn       = stn[0];
    bus.clearn      = cn[0];
    bus.door_closed = dc[0];
    bus.timer_done  = td[0];
    bus.tick        = tk[0];
    bus.power_level = LW'(pl);
    @(posedge clk);
    model_step(sn, stn, cn, dc, td, tk, pl);
    #1;
    check_eq("state",   int'(bus.state),   m_st);
    check_eq("mag_on",  int'(bus.mag_on),  m_mag);
    check_eq("cooking", int'(bus.cooking), (m_st == 1) ? 1 : 0);
    check_eq("done",    int'(bus.done),    (m_st == 3) ? 1 : 0);
    check_eq("win",     int'(dut.u_duty.win), m_win);
    @(negedge clk);
  endtask

  task automatic idle_cyc();
    cyc(1, 1, 1, 1, 0, 0, 0);
  endtask

  task automatic clear_it();
    cyc(1, 1, 0, 1, 0, 0, 0);
  endtask

  task automatic start_pulse(input int pl);
    cyc(1, 1, 1, 1, 0, 0, pl);
    cyc(0, 1, 1, 1, 0, 0, pl);
  endtask

  initial begin
    int cnt;
    int ps;
    n_cmp = 0;
    n_err = 0;
    bus.startn = 1'b1; bus.stopn = 1'b1; bus.clearn = 1'b1;
    bus.door_closed = 1'b1; bus.timer_done = 1'b0; bus.tick = 1'b0;
    bus.power_level = '0;
    resetn = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    check_eq("rst_state", int'(bus.state), 0);
    check_eq("rst_mag",   int'(bus.mag_on), 0);
    check_eq("rst_lvl",   int'(dut.lvl_q), 0);

    // Full power for 25 ticks, then timer expiry.
    start_pulse(10);
    check_eq("full_start", int'(bus.state), 1);
    cnt = 0;
    for (int i = 0; i < 25; i++) begin
      if (bus.mag_on) cnt++;
      cyc(1, 1, 1, 1, 0, 1, 0);
      idle_cyc();
    end
    check_eq("full_on_ticks", cnt, 25);
    cyc(1, 1, 1, 1, 1, 0, 0);
    check_eq("full_done", int'(bus.state), 3);
    check_eq("full_mag_off", int'(bus.mag_on), 0);
    clear_it();

    // Level 3 over three windows.
    start_pulse(3);
    cnt = 0;
    for (int i = 0; i < 30; i++) begin
      if (bus.mag_on) cnt++;
      cyc(1, 1, 1, 1, 0, 1, 0);
    end
    check_eq("lvl3_on_ticks", cnt, 9);
    clear_it();

    // Level 0 never fires.
    start_pulse(0);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      cyc(1, 1, 1, 1, 0, 1, 0);
      if (bus.mag_on) cnt++;
    end
    check_eq("lvl0_on", cnt, 0);
    clear_it();

    // Door open at win=2 pauses, resume keeps the window position.
    start_pulse(5);
    cyc(1, 1, 1, 1, 0, 1, 0);
    cyc(1, 1, 1, 1, 0, 1, 0);
    check_eq("door_win2", int'(dut.u_duty.win), 2);
    cyc(1, 1, 1, 0, 0, 0, 0);
    check_eq("door_pause", int'(bus.state), 2);
    check_eq("door_mag", int'(bus.mag_on), 0);
    cyc(1, 1, 1, 1, 0, 0, 0);
    cyc(0, 1, 1, 1, 0, 0, 0);
    check_eq("resume_state", int'(bus.state), 1);
    check_eq("resume_win", int'(dut.u_duty.win), 2);
    check_eq("resume_mag", int'(bus.mag_on), 1);
    clear_it();

    // Held start triggers exactly once; DONE ignores start until cleared.
    cnt = 0;
    for (int i = 0; i < 50; i++) begin
      ps = int'(bus.state);
      cyc(0, 1, 1, 1, 0, i % 3 == 0 ? 1 : 0, 7);
      if (ps == 0 && int'(bus.state) == 1) cnt++;
    end
    check_eq("held_start_once", cnt, 1);
    cyc(0, 1, 1, 1, 1, 0, 7);
    check_eq("held_done", int'(bus.state), 3);
    start_pulse(7);
    cyc(1, 1, 1, 1, 0, 0, 7);
    check_eq("done_ignores_start", int'(bus.state), 3);
    clear_it();
    check_eq("done_cleared", int'(bus.state), 0);

    // Clear beats a start edge while paused.
    start_pulse(4);
    cyc(1, 1, 1, 1, 0, 1, 4);
    cyc(1, 0, 1, 1, 0, 0, 4);
    check_eq("pause_stop", int'(bus.state), 2);
    cyc(1, 1, 1, 1, 0, 0, 4);
    cyc(0, 1, 0, 1, 0, 0, 4);
    check_eq("clear_wins", int'(bus.state), 0);
    check_eq("clear_win0", int'(dut.u_duty.win), 0);

    // Oversized level saturates.
    start_pulse(15);
    check_eq("sat_lvl", int'(dut.lvl_q), 10);
    check_eq("sat_mag", int'(bus.mag_on), 1);

    // Asynchronous reset mid-cook.
    @(posedge clk);
    #2;
    resetn = 1'b0;
    #1;
    check_eq("async_mag", int'(bus.mag_on), 0);
    check_eq("async_state", int'(bus.state), 0);
    model_reset();
    @(negedge clk);
    resetn = 1'b1;
    for (int i = 0; i < 5; i++) cyc(1, 1, 1, 1, 0, 1, 5);
    check_eq("post_rst_idle", int'(bus.state), 0);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(0, 9) < 3) ? 0 : 1,
          ($urandom_range(0, 99) < 5) ? 0 : 1,
          ($urandom_range(0, 99) < 3) ? 0 : 1,
          ($urandom_range(0, 99) < 6) ? 0 : 1,
          ($urandom_range(0, 99) < 3) ? 1 : 0,
          ($urandom_range(0, 9) < 4) ? 1 : 0,
          int'($urandom_range(0, 15)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
